// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit MEM-stage load/store serviced as two half-word accesses on a 16-bit async SRAM.
// Define SRAM_CTRL_LAST_READ_EN to add a one-entry last-load tag that answers repeated loads without an SRAM access.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [16:0] w, w_q;
  logic [15:0] wd_hi;
  logic wr_q, req, hit, last;
  assign w = 17'((address - 32'(BASE_ADDR)) >> 2);
  assign req = wr_en || rd_en;
  assign last = cnt == CW'(WAIT_CYCLES - 1);
  assign ready = state == DONE || (state == IDLE && (!req || hit));
`ifdef SRAM_CTRL_LAST_READ_EN
  logic [16:0] tag;
  logic tag_v;
  assign hit = rd_en && !wr_en && tag_v && tag == w;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag <= '0;
      tag_v <= 1'b0;
    end else if (state == LOW && wr_q) begin
      tag_v <= 1'b0;
    end else if (state == HIGH && last && !wr_q) begin
      tag <= w_q;
      tag_v <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      w_q <= '0;
      wd_hi <= '0;
      wr_q <= 1'b0;
      read_data <= '0;
      sram_addr <= '0;
      sram_dq_out <= '0;
      sram_we_n <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req && !hit) begin
          state <= LOW;
          cnt <= '0;
          w_q <= w;
          wd_hi <= write_data[31:16];
          wr_q <= wr_en;
          sram_addr <= {w, 1'b0};
          sram_dq_out <= write_data[15:0];
          sram_we_n <= !wr_en;
          sram_dq_oe <= wr_en;
        end
        LOW: if (last) begin
          if (!wr_q) read_data[15:0] <= sram_dq_in;
          state <= HIGH;
          cnt <= '0;
          sram_addr <= {w_q, 1'b1};
          sram_dq_out <= wd_hi;
        end else begin
          cnt <= cnt + 1'b1;
        end
        HIGH: if (last) begin
          if (!wr_q) read_data[31:16] <= sram_dq_in;
          state <= DONE;
          cnt <= '0;
          sram_we_n <= 1'b1;
          sram_dq_oe <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed checks of sram_ctrl against a small SRAM model (default and WAIT_CYCLES=1 instances).
module tb_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, write_data = '0, read_data;
  logic ready, sram_dq_oe, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic wr1 = 1'b0;
  logic [31:0] addr1 = '0, wd1 = '0, rd1;
  logic ready1, oe1, we1_n;
  logic [17:0] sram_addr1;
  logic [15:0] dq_out1;
  logic [15:0] mem [0:15];
  int n_cmp = 0, n_bad = 0;
  int n, highs;
  logic [31:0] exp_rd;
  always #5 clk = ~clk;
  sram_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );
  sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(1'b0), .address(addr1),
    .write_data(wd1), .read_data(rd1), .ready(ready1), .sram_addr(sram_addr1),
    .sram_dq_out(dq_out1), .sram_dq_in(16'h0), .sram_dq_oe(oe1), .sram_we_n(we1_n)
  );
  assign sram_dq_in = mem[sram_addr[3:0]];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] <= sram_dq_out;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, output int cyc);
    wr_en = w; rd_en = r; address = a; write_data = d;
    #1;
    cyc = 0;
    while (!ready && cyc < 40) begin
      tick();
      cyc++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("reset_ready", 32'(ready), 1);
    check("reset_we_n", 32'(sram_we_n), 1);
    check("reset_oe", 32'(sram_dq_oe), 0);
    check("reset_rdata", read_data, 0);
    check("reset_addr", 32'(sram_addr), 0);
    wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
    #1;
    check("st_idle_ready", 32'(ready), 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("st_addr", 32'(sram_addr), i <= 5 ? 0 : 1);
      check("st_dq", 32'(sram_dq_out), i <= 5 ? 32'hBEEF : 32'hDEAD);
      check("st_we_n", 32'(sram_we_n), 0);
      check("st_ready", 32'(ready), 0);
    end
    tick();
    check("st_done_ready", 32'(ready), 1);
    check("st_done_we_n", 32'(sram_we_n), 1);
    check("st_done_oe", 32'(sram_dq_oe), 0);
    wr_en = 1'b0;
    tick();
    check("st_after_ready", 32'(ready), 1);
    check("mem_lo", 32'(mem[0]), 32'hBEEF);
    check("mem_hi", 32'(mem[1]), 32'hDEAD);
    rd_en = 1'b1; address = 32'd1024;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("ld_ready", 32'(ready), 0);
      check("ld_we_n", 32'(sram_we_n), 1);
    end
    tick();
    check("ld_done_ready", 32'(ready), 1);
    check("ld_data", read_data, 32'hDEADBEEF);
    rd_en = 1'b0;
    tick();
    exp_rd = 32'hDEADBEEF;
`ifdef SRAM_CTRL_LAST_READ_EN
    do_req(1'b0, 1'b1, 32'd1024, 32'h0, n);
    check("hit_cycles", n, 0);
    check("hit_data", read_data, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, n);
    check("st2_cycles", n, 11);
    do_req(1'b0, 1'b1, 32'd1024, 32'h0, n);
    check("miss_cycles", n, 11);
    check("miss_data", read_data, 32'hCAFEF00D);
    exp_rd = 32'hCAFEF00D;
`endif
    wr_en = 1'b1; rd_en = 1'b1; address = 32'd1028; write_data = 32'h12345678;
    tick();
    check("both_lo_addr", 32'(sram_addr), 2);
    check("both_lo_dq", 32'(sram_dq_out), 32'h5678);
    check("both_we_n", 32'(sram_we_n), 0);
    for (int i = 0; i < 5; i++) tick();
    check("both_hi_addr", 32'(sram_addr), 3);
    check("both_hi_dq", 32'(sram_dq_out), 32'h1234);
    for (int i = 0; i < 5; i++) tick();
    check("both_ready", 32'(ready), 1);
    check("both_rdata", read_data, exp_rd);
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    check("mem_2", 32'(mem[2]), 32'h5678);
    check("mem_3", 32'(mem[3]), 32'h1234);
    wr1 = 1'b1; addr1 = 32'd1032; wd1 = 32'h0BAD_F00D;
    #1;
    check("b2b_first_ready", 32'(ready1), 0);
    highs = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (ready1) highs++;
      if (i == 1) check("b2b_addr0", 32'(sram_addr1), 4);
      if (i == 5) check("b2b_addr1", 32'(sram_addr1), 6);
      if (i == 3) begin
        check("b2b_done0", 32'(ready1), 1);
        addr1 = 32'd1036;
      end
      if (i == 7) begin
        check("b2b_done1", 32'(ready1), 1);
        wr1 = 1'b0;
      end
    end
    check("b2b_highs", highs, 2);
    tick();
    check("b2b_idle_ready", 32'(ready1), 1);
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hAAAA5555;
    for (int i = 0; i < 7; i++) tick();
    check("rst_pre_addr", 32'(sram_addr), 9);
    check("rst_pre_we_n", 32'(sram_we_n), 0);
    rst = 1'b0; wr_en = 1'b0;
    #1;
    check("rst_we_n", 32'(sram_we_n), 1);
    check("rst_oe", 32'(sram_dq_oe), 0);
    check("rst_rdata", read_data, 0);
    tick();
    rst = 1'b1;
    tick();
    check("rst_ready", 32'(ready), 1);
    tick();
    check("rst_idle_we_n", 32'(sram_we_n), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
